// File: rtl/sm3_msg_src_pkg.sv
// Shared types and helpers for the SM3 message source / digest checker.
// Covers the FSM state set, the LFSR polynomial and the last-beat masking rule.
package sm3_msg_src_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RES = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  m;
    } beat_t;

    // Right-shifting Galois form: the bit shifted out of the LSB selects the tap mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

    // Keeps the first 'unalign' bytes (MSB side) of a bpb-byte beat and zeroes the rest.
    // unalign == 0 means the last beat is completely full.
    function automatic beat_t last_beat(input logic [63:0] data, input logic [2:0] unalign,
                                        input int bpb);
        beat_t r;
        int    k;
        r.d = '0;
        r.m = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < bpb) begin
                k = bpb - 1 - b;
                if (unalign == '0 || k < int'(unalign)) begin
                    r.m[b]         = 1'b1;
                    r.d[8*b +: 8]  = data[8*b +: 8];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sm3_msg_src_lfsr32.sv
// 32-bit Galois LFSR word generator; STEPS words are consumed per step_i.
// nxt_o exposes the word following val_o so a 64-bit beat can carry two words.
module sm3_msg_src_lfsr32
    import sm3_msg_src_pkg::*;
#(
    parameter int STEPS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        step_i,
    output logic [31:0] val_o,
    output logic [31:0] nxt_o
);

    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] adv;

    assign nxt_o = lfsr_step(lfsr_q);
    assign adv   = (STEPS == 2) ? lfsr_step(nxt_o) : nxt_o;
    assign val_o = lfsr_q;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = load_val_i;
        end else if (step_i) begin
            lfsr_d = adv;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 32'h1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/sm3_msg_src.sv
// Message source and digest checker for the SM3 core input interface.
// Optional macro SM3_MSG_SRC_GAP_EN inserts one idle cycle after each non-last beat.
module sm3_msg_src
    import sm3_msg_src_pkg::*;
#(
    parameter int DW    = 32,
    parameter int LEN_W = 61,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  byte_num,
    input  logic              pat_mode,
    input  logic [31:0]       seed,
    input  logic [255:0]      exp_res,
    output logic [DW-1:0]     msg_inpt_d,
    output logic [DW/8-1:0]   msg_inpt_vld_byte,
    output logic              msg_inpt_vld,
    output logic              msg_inpt_lst,
    input  logic              msg_inpt_rdy,
    input  logic              cmprss_otpt_vld,
    input  logic [255:0]      cmprss_otpt_res,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  test_cnt,
    output logic [CNT_W-1:0]  ok_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam int BPB = DW / 8;
    localparam int UW  = $clog2(BPB);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   beats_left_q, beats_left_d;
    logic [UW-1:0]      unalign_q, unalign_d;
    logic               pat_mode_q, pat_mode_d;
    logic [31:0]        pat_word_q, pat_word_d;
    logic [255:0]       exp_res_q, exp_res_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic               gap_q, gap_d;
    logic [CNT_W-1:0]   test_cnt_q, test_cnt_d;
    logic [CNT_W-1:0]   ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;

    logic               vld, xfer, is_last, start_ok;
    logic [31:0]        lfsr_val, lfsr_nxt, word_hi, word_lo;
    logic [63:0]        raw, d_all;
    logic [7:0]         m_all;
    beat_t              lb;

    // vld depends only on registered state, never on rdy.
    assign vld      = (state_q == SEND) && !gap_q;
    assign xfer     = vld && msg_inpt_rdy;
    assign is_last  = (beats_left_q == LEN_W'(1));
    assign start_ok = (state_q == IDLE) && start && (byte_num != '0);

    sm3_msg_src_lfsr32 #(.STEPS(DW / 32)) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (start_ok),
        .load_val_i ((seed == 32'h0) ? 32'h1 : seed),
        .step_i     (xfer),
        .val_o      (lfsr_val),
        .nxt_o      (lfsr_nxt)
    );

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        unalign_d    = unalign_q;
        pat_mode_d   = pat_mode_q;
        pat_word_d   = pat_word_q;
        exp_res_d    = exp_res_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        cfg_err_d    = cfg_err_q;
        gap_d        = 1'b0;
        test_cnt_d   = test_cnt_q;
        ok_cnt_d     = ok_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (byte_num == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d      = SEND;
                        beats_left_d = (byte_num >> UW) + LEN_W'(|byte_num[UW-1:0]);
                        unalign_d    = byte_num[UW-1:0];
                        pat_mode_d   = pat_mode;
                        pat_word_d   = seed;
                        exp_res_d    = exp_res;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    if (is_last) begin
                        state_d = WAIT_RES;
                    end else begin
                        beats_left_d = beats_left_q - LEN_W'(1);
`ifdef SM3_MSG_SRC_GAP_EN
                        gap_d = 1'b1;
`endif
                    end
                end
            end
            WAIT_RES: begin
                if (cmprss_otpt_vld) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    pass_d     = (cmprss_otpt_res == exp_res_q);
                    test_cnt_d = (&test_cnt_q) ? test_cnt_q : test_cnt_q + CNT_W'(1);
                    if (cmprss_otpt_res == exp_res_q) begin
                        ok_cnt_d = (&ok_cnt_q) ? ok_cnt_q : ok_cnt_q + CNT_W'(1);
                    end else begin
                        fail_cnt_d = (&fail_cnt_q) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            unalign_q    <= '0;
            pat_mode_q   <= 1'b0;
            pat_word_q   <= '0;
            exp_res_q    <= '0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            gap_q        <= 1'b0;
            test_cnt_q   <= '0;
            ok_cnt_q     <= '0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            unalign_q    <= unalign_d;
            pat_mode_q   <= pat_mode_d;
            pat_word_q   <= pat_word_d;
            exp_res_q    <= exp_res_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            gap_q        <= gap_d;
            test_cnt_q   <= test_cnt_d;
            ok_cnt_q     <= ok_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    // Beat assembly on a 64-bit scratch bus; DW = 32 uses only the low half.
    assign word_hi = pat_mode_q ? pat_word_q : lfsr_val;
    assign word_lo = pat_mode_q ? pat_word_q : lfsr_nxt;
    assign raw     = (DW == 64) ? {word_hi, word_lo} : {32'h0, word_hi};

    always_comb begin
        lb    = last_beat(raw, 3'(unalign_q), BPB);
        d_all = 64'h0;
        m_all = 8'hFF;
        if (vld) begin
            d_all = is_last ? lb.d : raw;
            if (is_last) begin
                m_all = lb.m;
            end
        end
    end

    if (DW == 64) begin : g_dw64
        assign msg_inpt_d        = d_all;
        assign msg_inpt_vld_byte = m_all;
    end else begin : g_dw32
        logic unused_hi;
        assign msg_inpt_d        = d_all[31:0];
        assign msg_inpt_vld_byte = m_all[3:0];
        assign unused_hi         = ^{d_all[63:32], m_all[7:4]};
    end

    assign msg_inpt_vld = vld;
    assign msg_inpt_lst = vld && is_last;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign pass         = pass_q;
    assign cfg_err      = cfg_err_q;
    assign test_cnt     = test_cnt_q;
    assign ok_cnt       = ok_cnt_q;
    assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_sm3_msg_src.sv
// Self-checking bench for sm3_msg_src: a 32-bit instance and a 64-bit instance
// with 2-bit counters, checked against a byte-stream reference model.
module tb_sm3_msg_src;

`ifdef SM3_MSG_SRC_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start32, start64, pat_mode, rdy, cvld, sel;
    logic [60:0]  byte_num;
    logic [31:0]  seed;
    logic [255:0] exp_res, cres;

    logic [31:0] d32, tc32, oc32, fc32;
    logic [3:0]  vb32;
    logic        vld32, lst32, busy32, done32, pass32, cerr32;
    logic [63:0] d64;
    logic [7:0]  vb64;
    logic [1:0]  tc64, oc64, fc64;
    logic        vld64, lst64, busy64, done64, pass64, cerr64;

    sm3_msg_src #(.DW(32), .LEN_W(61), .CNT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .byte_num(byte_num), .pat_mode(pat_mode),
        .seed(seed), .exp_res(exp_res), .msg_inpt_d(d32), .msg_inpt_vld_byte(vb32),
        .msg_inpt_vld(vld32), .msg_inpt_lst(lst32), .msg_inpt_rdy(rdy),
        .cmprss_otpt_vld(cvld), .cmprss_otpt_res(cres), .busy(busy32), .done(done32),
        .pass(pass32), .cfg_err(cerr32), .test_cnt(tc32), .ok_cnt(oc32), .fail_cnt(fc32)
    );

    sm3_msg_src #(.DW(64), .LEN_W(61), .CNT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .byte_num(byte_num), .pat_mode(pat_mode),
        .seed(seed), .exp_res(exp_res), .msg_inpt_d(d64), .msg_inpt_vld_byte(vb64),
        .msg_inpt_vld(vld64), .msg_inpt_lst(lst64), .msg_inpt_rdy(rdy),
        .cmprss_otpt_vld(cvld), .cmprss_otpt_res(cres), .busy(busy64), .done(done64),
        .pass(pass64), .cfg_err(cerr64), .test_cnt(tc64), .ok_cnt(oc64), .fail_cnt(fc64)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: completed tests per instance and sticky cfg_err.
    int n_test[2], n_ok[2], n_fail[2];
    bit m_cerr[2];

    function automatic logic [63:0] o_d();  return sel ? d64 : {32'h0, d32};            endfunction
    function automatic logic [7:0]  o_vb(); return sel ? vb64 : {4'h0, vb32};           endfunction
    function automatic logic o_vld();  return sel ? vld64  : vld32;  endfunction
    function automatic logic o_lst();  return sel ? lst64  : lst32;  endfunction
    function automatic logic o_busy(); return sel ? busy64 : busy32; endfunction
    function automatic logic o_done(); return sel ? done64 : done32; endfunction
    function automatic logic o_pass(); return sel ? pass64 : pass32; endfunction
    function automatic logic o_cerr(); return sel ? cerr64 : cerr32; endfunction
    function automatic logic [31:0] o_tc(); return sel ? {30'h0, tc64} : tc32; endfunction
    function automatic logic [31:0] o_oc(); return sel ? {30'h0, oc64} : oc32; endfunction
    function automatic logic [31:0] o_fc(); return sel ? {30'h0, fc64} : fc32; endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [31:0] sat(input int n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (longint'(n) > mx) ? 32'(mx) : 32'(n);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag, input int idx);
        int cw;
        cw  = (idx == 1) ? 2 : 32;
        sel = (idx == 1);
        check({tag, "_cfg_err"},  64'(o_cerr()), 64'(m_cerr[idx]));
        check({tag, "_test_cnt"}, 64'(o_tc()),   64'(sat(n_test[idx], cw)));
        check({tag, "_ok_cnt"},   64'(o_oc()),   64'(sat(n_ok[idx], cw)));
        check({tag, "_fail_cnt"}, 64'(o_fc()),   64'(sat(n_fail[idx], cw)));
    endtask

    task automatic reset_checks(input int idx);
        sel = (idx == 1);
        check("rst_vld",  64'(o_vld()),  64'(0));
        check("rst_busy", 64'(o_busy()), 64'(0));
        check("rst_d",    o_d(),         64'(0));
        check("rst_lst",  64'(o_lst()),  64'(0));
        check("rst_done", 64'(o_done()), 64'(0));
        check("rst_pass", 64'(o_pass()), 64'(0));
        check("rst_vb",   64'(o_vb()),   (idx == 1) ? 64'hFF : 64'hF);
        check_stats("rst", idx);
    endtask

    // Sends one message and plays the SM3 core: accepts beats with random or
    // directed rdy, then returns digest 'res'. Negative *_at arguments disable the option.
    task automatic run_msg(input bit w64, input int nbytes, input bit pm, input logic [31:0] sd,
                           input logic [255:0] expd, input logic [255:0] res,
                           input int stall_at, input int mid_start_at, input int abort_at,
                           input bit rand_rdy);
        int          idx, bpb, nbeats, k, cyc, stall_cnt, bi, sh, delay;
        logic [31:0] words[$];
        logic [31:0] w;
        logic [7:0]  by, e_m, h_m;
        logic [63:0] e_d, h_d;
        bit          stalled, chk_next, chk_gap, mid_done, h_l;
        idx    = w64 ? 1 : 0;
        sel    = w64;
        bpb    = w64 ? 8 : 4;
        nbeats = (nbytes + bpb - 1) / bpb;
        w      = (sd == 32'h0) ? 32'h1 : sd;
        for (int i = 0; i < nbeats * bpb / 4; i++) begin
            words.push_back(pm ? sd : w);
            w = lfsr_next(w);
        end

        @(negedge clk);
        byte_num = 61'(nbytes); pat_mode = pm; seed = sd; exp_res = expd; rdy = 1'b0;
        if (w64) start64 = 1'b1; else start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; start64 = 1'b0;
        // Scramble the config inputs: the DUT must work from its latched copy.
        byte_num = 61'($urandom_range(0, 7)); pat_mode = ~pm; seed = $urandom; exp_res = ~expd;
        check("busy_after_start", 64'(o_busy()), 64'(1));
        check("first_beat_vld",   64'(o_vld()),  64'(1));

        k = 0; cyc = 0; stall_cnt = 0;
        stalled = 0; chk_next = 0; chk_gap = 0; mid_done = 0;
        while (k < nbeats && cyc < 2000) begin
            if (stalled) begin
                check("hold_vld", 64'(o_vld()), 64'(1));
                check("hold_d",   o_d(),        h_d);
                check("hold_vb",  64'(o_vb()),  64'(h_m));
                check("hold_lst", 64'(o_lst()), 64'(h_l));
            end
            if (chk_gap) begin
                check("after_gap_vld", 64'(o_vld()), 64'(1));
                chk_gap = 0;
            end
            if (chk_next) begin
                check("next_beat_vld", 64'(o_vld()), GAP ? 64'(0) : 64'(1));
                chk_gap  = GAP;
                chk_next = 0;
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < 2; i++) begin
                    n_test[i] = 0; n_ok[i] = 0; n_fail[i] = 0; m_cerr[i] = 0;
                end
                sel = w64;
                check("abort_vld",  64'(o_vld()),  64'(0));
                check("abort_busy", 64'(o_busy()), 64'(0));
                check_stats("abort", idx);
                @(negedge clk);
                rst_n = 1'b1; rdy = 1'b0;
                return;
            end
            if (k == stall_at && stall_cnt < 10) begin
                rdy = 1'b0;
                stall_cnt++;
            end else begin
                rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (k == mid_start_at && !mid_done) begin
                byte_num = '0;
                if (w64) start64 = 1'b1; else start32 = 1'b1;
                mid_done = 1;
            end else begin
                start32 = 1'b0; start64 = 1'b0;
            end
            stalled = o_vld() && !rdy;
            h_d = o_d(); h_m = o_vb(); h_l = o_lst();
            if (o_vld() && rdy) begin
                e_d = '0; e_m = '0;
                for (int j = 0; j < bpb; j++) begin
                    bi = k * bpb + j;
                    sh = (bpb - 1 - j) * 8;
                    by = 8'(words[bi / 4] >> ((3 - bi % 4) * 8));
                    if (bi < nbytes) begin
                        e_d = e_d | (64'(by) << sh);
                        e_m[bpb-1-j] = 1'b1;
                    end
                end
                check("beat_d",   o_d(),        e_d);
                check("beat_vb",  64'(o_vb()),  64'(e_m));
                check("beat_lst", 64'(o_lst()), 64'(k == nbeats - 1));
                chk_next = (k != nbeats - 1);
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        start32 = 1'b0; start64 = 1'b0; rdy = 1'b0;
        check("beats_before_timeout", 64'(k), 64'(nbeats));
        check("post_last_vld",  64'(o_vld()),  64'(0));
        check("post_last_lst",  64'(o_lst()),  64'(0));
        check("wait_res_busy",  64'(o_busy()), 64'(1));

        delay = $urandom_range(0, 3);
        repeat (delay) begin
            @(negedge clk);
            check("wait_res_no_done", 64'(o_done()), 64'(0));
        end
        cvld = 1'b1; cres = res;
        @(negedge clk);
        cvld = 1'b0; cres = rand256();
        n_test[idx]++;
        if (res == expd) n_ok[idx]++; else n_fail[idx]++;
        check("done_pulse",   64'(o_done()), 64'(1));
        check("pass_value",   64'(o_pass()), 64'(res == expd));
        check("idle_busy",    64'(o_busy()), 64'(0));
        check_stats("result", idx);
        @(negedge clk);
        check("done_one_cycle", 64'(o_done()), 64'(0));
        check("pass_held",      64'(o_pass()), 64'(res == expd));
    endtask

    logic [255:0] dig1, dig2, r;
    logic         w64r;
    int           nb;

    initial begin
        rst_n = 1'b0; start32 = 1'b0; start64 = 1'b0; byte_num = '0; pat_mode = 1'b0;
        seed = '0; exp_res = '0; rdy = 1'b0; cvld = 1'b0; cres = '0; sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_test[i] = 0; n_ok[i] = 0; n_fail[i] = 0; m_cerr[i] = 0;
        end
        dig1 = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
        dig2 = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
        repeat (3) @(negedge clk);
        reset_checks(0);
        reset_checks(1);
        rst_n = 1'b1;

        // "abc": one short beat
        run_msg(1'b0, 3, 1'b1, 32'h6162_6364, dig1, dig1, -1, -1, -1, 1'b0);
        // 64-byte pattern message with random back-pressure
        run_msg(1'b0, 64, 1'b1, 32'h6162_6364, dig2, dig2, -1, -1, -1, 1'b1);
        // 5 bytes, 10-cycle rdy stall on the last beat
        r = rand256();
        run_msg(1'b0, 5, 1'b1, 32'hAABB_CCDD, r, r, 1, -1, -1, 1'b0);
        // wrong digest; start with byte_num 0 during SEND is ignored
        r = rand256();
        run_msg(1'b0, 20, 1'b0, $urandom, r, ~r, -1, 2, -1, 1'b1);

        // zero-length start: cfg_err, no beats
        @(negedge clk);
        sel = 1'b0; byte_num = '0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; m_cerr[0] = 1;
        check("zero_len_busy", 64'(o_busy()), 64'(0));
        check("zero_len_vld",  64'(o_vld()),  64'(0));
        check_stats("zero_len", 0);

        // digest valid while idle is ignored
        cvld = 1'b1; cres = rand256();
        @(negedge clk);
        cvld = 1'b0;
        check("idle_res_no_done", 64'(o_done()), 64'(0));
        check_stats("idle_res", 0);

        // reset during beat 4, then a fresh message
        r = rand256();
        run_msg(1'b0, 32, 1'b0, $urandom, r, r, -1, -1, 3, 1'b0);
        r = rand256();
        run_msg(1'b0, 9, 1'b0, $urandom, r, r, -1, -1, -1, 1'b1);

        // 64-bit bus, LFSR seed 1, 13 bytes
        r = rand256();
        run_msg(1'b1, 13, 1'b0, 32'h1, r, r, -1, -1, -1, 1'b0);

        // randomized traffic on both widths; dut64 counters saturate at 3
        for (int i = 0; i < 8; i++) begin
            w64r = i[0];
            nb   = $urandom_range(1, 40);
            r    = rand256();
            run_msg(w64r, nb, 1'($urandom_range(0, 1)), (i == 2) ? 32'h0 : $urandom,
                    r, ($urandom_range(0, 1) == 1) ? r : r ^ 256'h1,
                    $urandom_range(0, 4), -1, -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
